// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and
// iteration-counter sizing.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // One extra bit so the counter can hold WIDTH itself without wrapping.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/claAdder.sv
// WIDTH-bit adder built from 4-bit carry-lookahead groups chained group to group.
// WIDTH must be a multiple of 4.
module claAdder #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NGRP = WIDTH / 4;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic             grp_c [0:NGRP];

  assign g = a & b;
  assign p = a ^ b;
  assign grp_c[0] = cin;
  assign cout = grp_c[NGRP];

  genvar gi;
  generate
    for (gi = 0; gi < NGRP; gi++) begin : g_grp
      logic [3:0] gg;
      logic [3:0] pp;
      logic       c0;
      logic [3:0] c;
      assign gg = g[gi*4 +: 4];
      assign pp = p[gi*4 +: 4];
      assign c0 = grp_c[gi];
      assign c[0] = c0;
      assign c[1] = gg[0] | (pp[0] & c0);
      assign c[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & c0);
      assign c[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                  | (pp[2] & pp[1] & pp[0] & c0);
      assign grp_c[gi+1] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                         | (pp[3] & pp[2] & pp[1] & gg[0]) | ((&pp) & c0);
      assign sum[gi*4 +: 4] = pp ^ c;
    end
  endgenerate

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per cycle, WIDTH+1 cycle latency.
// Optional signed mode is enabled with macro SEQ_DIVIDER_SIGNED_EN.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef SEQ_DIVIDER_SIGNED_EN
  input  logic             is_signed,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dsr_q;
  logic [WIDTH-1:0] rem_q;
  logic             qneg_q;
  logic             rneg_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] quot_out_q;
  logic [WIDTH-1:0] rem_out_q;
  logic             dz_q;

  logic             a_neg_d;
  logic             b_neg_d;
  logic [WIDTH-1:0] a_mag_d;
  logic [WIDTH-1:0] b_mag_d;

  always_comb begin
    a_neg_d = 1'b0;
    b_neg_d = 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
    a_neg_d = is_signed & dividend[WIDTH-1];
    b_neg_d = is_signed & divisor[WIDTH-1];
`endif
    a_mag_d = a_neg_d ? -dividend : dividend;
    b_mag_d = b_neg_d ? -divisor : divisor;
  end

  // The dividend register doubles as the quotient: bits shift out the top
  // into the partial remainder while quotient bits shift in at the bottom.
  logic [WIDTH:0]   shifted_d;
  logic [WIDTH-1:0] diff_d;
  logic             cout_d;
  logic             nonneg_d;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;
  logic             dsr_zero_d;
  logic [WIDTH-1:0] quo_fix_d;
  logic [WIDTH-1:0] rem_fix_d;

  assign shifted_d = {rem_q, dvd_q[WIDTH-1]};

  claAdder #(.WIDTH(WIDTH)) u_cla (
    .a    (shifted_d[WIDTH-1:0]),
    .b    (~dsr_q),
    .cin  (1'b1),
    .sum  (diff_d),
    .cout (cout_d)
  );

  assign nonneg_d   = cout_d | shifted_d[WIDTH];
  assign rem_d      = nonneg_d ? diff_d : shifted_d[WIDTH-1:0];
  assign quo_d      = {dvd_q[WIDTH-2:0], nonneg_d};
  assign dsr_zero_d = (dsr_q == '0);
  // Divide-by-zero keeps the all-ones quotient; the remainder fixup then
  // reproduces the raw dividend.
  assign quo_fix_d  = (qneg_q && !dsr_zero_d) ? -quo_d : quo_d;
  assign rem_fix_d  = rneg_q ? -rem_d : rem_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      dvd_q      <= '0;
      dsr_q      <= '0;
      rem_q      <= '0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      quot_out_q <= '0;
      rem_out_q  <= '0;
      dz_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            dvd_q   <= a_mag_d;
            dsr_q   <= b_mag_d;
            rem_q   <= '0;
            cnt_q   <= '0;
            qneg_q  <= a_neg_d ^ b_neg_d;
            rneg_q  <= a_neg_d;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          dvd_q <= quo_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) begin
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            quot_out_q <= quo_fix_d;
            rem_out_q  <= rem_fix_d;
            dz_q       <= dsr_zero_d;
            state_q    <= ST_DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quot_out_q;
  assign remainder = rem_out_q;
  assign div_zero  = dz_q;

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand/result width; legal values: multiple of 4, >= 8.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE or DONE.
REQ-005 SHALL have port dividend  input  WIDTH  numerator; sampled with accepted start.
REQ-006 SHALL have port divisor  input  WIDTH  denominator; sampled with accepted start.
REQ-007 SHALL have port busy  output  1  high while an operation is in progress (RUN).
REQ-008 SHALL have port done  output  1  one-cycle pulse; results valid.
REQ-009 SHALL have port quotient  output  WIDTH  registered result.
REQ-010 SHALL have port remainder  output  WIDTH  registered result.
REQ-011 SHALL have port div_zero  output  1  registered; set when the completed operation had divisor == 0.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
- IDLE: start=1 -> RUN.
- RUN: after WIDTH iterations -> DONE.
- DONE: start=1 -> RUN, else -> IDLE.
REQ-013 SHALL capture operands on the edge where start is accepted; later operand changes SHALL NOT affect the operation.
REQ-014 SHALL compute one quotient bit per RUN cycle by restoring division:
- shift the (WIDTH+1)-bit partial remainder left by 1, bringing in the next dividend bit, MSB first;
- perform a trial subtraction of the divisor;
- keep the trial result and set the quotient bit to 1 if it is non-negative, else restore and set the quotient bit to 0.
REQ-015 SHALL assert done exactly WIDTH+1 cycles after the start-accept cycle, for exactly one cycle; busy SHALL be high for the WIDTH RUN cycles only.
REQ-016 SHALL update quotient, remainder and div_zero only on the edge entering DONE; they SHALL hold until the next completion.
REQ-017 SHALL ignore start while in RUN; there is no queueing.
REQ-018 SHALL treat divisor == 0 as a normal operation with the same latency: quotient = all ones, remainder = dividend, div_zero = 1.
REQ-019 SHALL accept start in DONE, giving back-to-back operations with no idle cycle.

Reset
REQ-020 SHALL, on a clock edge with rst=1, force IDLE with busy=0, done=0, quotient=0, remainder=0, div_zero=0; the working registers SHALL also be cleared.
REQ-021 SHALL abort an in-flight operation on reset; no done pulse SHALL be produced for it.
REQ-022 SHALL give rst priority over start on the same edge.

Configuration
REQ-023 SHALL support macro SEQ_DIVIDER_SIGNED_EN.
REQ-024 With SEQ_DIVIDER_SIGNED_EN defined, SHALL add an input port is_signed (1 bit), sampled with start. When is_signed=1:
- operands are two's complement; the unsigned core runs on their magnitudes;
- the quotient is negated if the operand signs differ (truncation toward zero);
- the remainder takes the dividend's sign;
- the sign fixup is applied on the edge entering DONE, so latency is unchanged;
- divide-by-zero follows REQ-018 using the raw dividend.
REQ-025 Without SEQ_DIVIDER_SIGNED_EN, SHALL have no is_signed port and SHALL perform unsigned division only.

Structure
REQ-026 SHALL take the FSM state encodings (IDLE, RUN, DONE) and the iteration-counter width (clog2(WIDTH)+1) from shared package seq_divider_pkg.
REQ-027 SHALL perform the trial subtraction with one instance of the team's existing WIDTH-bit carry-lookahead adder module, claAdder:
- inputs A = shifted remainder low bits, B = ~divisor, Cin = 1;
- non-negative = Cout OR (shifted remainder MSB).
REQ-028 SHALL contain no other sub-modules; the counter and registers are local.

Verification (WIDTH=8 unless noted)
REQ-029 Unsigned: start with dividend=100, divisor=7 -> done 9 cycles after start, quotient=14, remainder=2, div_zero=0.
REQ-030 Divide-by-zero: dividend=200, divisor=0 -> done after 9 cycles, quotient=255, remainder=200, div_zero=1.
REQ-031 Start held high through RUN with new operands (50/5) -> ignored; first result 100/7 is unchanged; DONE then accepts 50/5 back-to-back -> quotient=10, remainder=0.
REQ-032 Reset asserted at RUN cycle 4 -> busy=0 next cycle, no done pulse, all outputs 0; a fresh 9/3 then yields quotient=3, remainder=0.
REQ-033 Signed (SEQ_DIVIDER_SIGNED_EN defined, is_signed=1): -7/2 -> quotient=-3 (0xFD), remainder=-1 (0xFF); 7/-2 -> quotient=0xFD, remainder=1.
REQ-034 WIDTH=64 randomized: 1000 operand pairs, including divisor=1 and dividend<divisor -> results match a reference model, with done exactly 65 cycles after each start.
